// File: rtl/rcc_cfg_sequencer.sv
// rcc_cfg_sequencer: drains APB, gates PCLKG and reloads the RCC clock dividers on request.
module rcc_cfg_sequencer #(
    parameter int SCALE1        = 8,
    parameter int SCALE2        = 8,
    parameter int SCALE3        = 8,
    parameter int DEF_DIV       = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int RST_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              CFG_REQ,
    input  logic [SCALE1-1:0] CFG_PCLK_DIV,
    input  logic [SCALE2-1:0] CFG_TIM_DIV,
    input  logic [SCALE3-1:0] CFG_WDOG_DIV,
    input  logic              CFG_RST_PERIPH,
    input  logic              APB_REQ,
    input  logic              APB_BUSY,
    output logic              APB_ACTIVE,
    output logic              APB_HOLD,
    output logic [SCALE1-1:0] PCLK_PCLKG_DIV,
    output logic [SCALE2-1:0] TIMCLK_DIV,
    output logic [SCALE3-1:0] WDOGCLK_DIV,
    output logic              PERIPH_RESETn,
    output logic              CFG_ACK,
    output logic              CFG_ERR,
    output logic              BUSY
);
    localparam int CM1  = SETTLE_CYCLES > RST_CYCLES ? SETTLE_CYCLES : RST_CYCLES;
    localparam int CMAX = CM1 > DRAIN_TIMEOUT ? CM1 : DRAIN_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_RSTP   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CW-1:0]     r_cnt;
    logic [SCALE1-1:0] r_pclk_cap;
    logic [SCALE2-1:0] r_tim_cap;
    logic [SCALE3-1:0] r_wdog_cap;
    logic              r_rst_cap;
    logic              w_zero;

    assign w_zero = (CFG_PCLK_DIV == '0) | (CFG_TIM_DIV == '0) | (CFG_WDOG_DIV == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = CFG_REQ ? (w_zero ? S_DONE : S_DRAIN) : S_IDLE;
            S_DRAIN:  w_next = !APB_BUSY ? S_GATE : (r_cnt == CW'(DRAIN_TIMEOUT - 1) ? S_DONE : S_DRAIN);
            S_GATE:   w_next = S_LOAD;
            S_LOAD:   w_next = S_SETTLE;
            S_SETTLE: w_next = r_cnt == CW'(SETTLE_CYCLES - 1) ? (r_rst_cap ? S_RSTP : S_DONE) : S_SETTLE;
            S_RSTP:   w_next = r_cnt == CW'(RST_CYCLES - 1) ? S_DONE : S_RSTP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_pclk_cap     <= '0;
            r_tim_cap      <= '0;
            r_wdog_cap     <= '0;
            r_rst_cap      <= 1'b0;
            PCLK_PCLKG_DIV <= SCALE1'(DEF_DIV);
            TIMCLK_DIV     <= SCALE2'(DEF_DIV);
            WDOGCLK_DIV    <= SCALE3'(DEF_DIV);
            APB_ACTIVE     <= 1'b0;
            APB_HOLD       <= 1'b0;
            PERIPH_RESETn  <= 1'b1;
            CFG_ACK        <= 1'b0;
            CFG_ERR        <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : (r_cnt == CW'(CMAX) ? r_cnt : r_cnt + 1'b1);
            if (r_state == S_IDLE && CFG_REQ) begin
                r_pclk_cap <= CFG_PCLK_DIV;
                r_tim_cap  <= CFG_TIM_DIV;
                r_wdog_cap <= CFG_WDOG_DIV;
                r_rst_cap  <= CFG_RST_PERIPH;
            end
            if (w_next == S_LOAD) begin
                PCLK_PCLKG_DIV <= r_pclk_cap;
                TIMCLK_DIV     <= r_tim_cap;
                WDOGCLK_DIV    <= r_wdog_cap;
            end
            APB_ACTIVE    <= (w_next == S_DRAIN) | (r_state == S_IDLE && w_next == S_IDLE && APB_REQ);
            APB_HOLD      <= (w_next != S_IDLE) && (w_next != S_DONE);
            PERIPH_RESETn <= w_next != S_RSTP;
            CFG_ACK       <= w_next == S_DONE;
            // DONE is reached from IDLE only on a zero ratio and from DRAIN only on timeout.
            CFG_ERR       <= (w_next == S_DONE) && (r_state == S_IDLE || r_state == S_DRAIN);
            BUSY          <= w_next != S_IDLE;
        end
    end
endmodule

// File: tb/tb_rcc_cfg_sequencer.sv
// tb_rcc_cfg_sequencer: directed vector table plus hand sequences for the clock-divider sequencer.
module tb_rcc_cfg_sequencer;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       CFG_REQ = 1'b0;
    logic [7:0] CFG_PCLK_DIV = 8'd0;
    logic [7:0] CFG_TIM_DIV = 8'd0;
    logic [7:0] CFG_WDOG_DIV = 8'd0;
    logic       CFG_RST_PERIPH = 1'b0;
    logic       APB_REQ = 1'b0;
    logic       APB_BUSY = 1'b0;
    logic       APB_ACTIVE, APB_HOLD, PERIPH_RESETn, CFG_ACK, CFG_ERR, BUSY;
    logic [7:0] PCLK_PCLKG_DIV, TIMCLK_DIV, WDOGCLK_DIV;

    rcc_cfg_sequencer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .CFG_REQ(CFG_REQ),
        .CFG_PCLK_DIV(CFG_PCLK_DIV), .CFG_TIM_DIV(CFG_TIM_DIV), .CFG_WDOG_DIV(CFG_WDOG_DIV),
        .CFG_RST_PERIPH(CFG_RST_PERIPH), .APB_REQ(APB_REQ), .APB_BUSY(APB_BUSY),
        .APB_ACTIVE(APB_ACTIVE), .APB_HOLD(APB_HOLD), .PCLK_PCLKG_DIV(PCLK_PCLKG_DIV),
        .TIMCLK_DIV(TIMCLK_DIV), .WDOGCLK_DIV(WDOGCLK_DIV), .PERIPH_RESETn(PERIPH_RESETn),
        .CFG_ACK(CFG_ACK), .CFG_ERR(CFG_ERR), .BUSY(BUSY)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0] p, t, w;
        logic       rst;
        int         busy;
        int         lat;
        logic       err;
        logic [7:0] ep, et, ew;
        int         lows;
    } vec_t;

    vec_t v[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a request sampled at the next rising edge, then drop it and scramble the inputs.
    task automatic launch(input logic [7:0] p, input logic [7:0] t, input logic [7:0] w, input logic r);
        @(negedge HCLK);
        CFG_PCLK_DIV = p; CFG_TIM_DIV = t; CFG_WDOG_DIV = w; CFG_RST_PERIPH = r;
        CFG_REQ = 1'b1;
        @(posedge HCLK); #1;
        CFG_REQ = 1'b0;
        CFG_PCLK_DIV = 8'hA5; CFG_TIM_DIV = 8'h5A; CFG_WDOG_DIV = 8'h3C; CFG_RST_PERIPH = ~r;
    endtask

    // Cycle n is the one ending at the n-th edge after the request edge.
    task automatic wait_ack(input int busy, output int lat, output logic err, output logic hold,
                            output int lows, output int first_low);
        lat = -1; err = 1'bx; hold = 1'bx; lows = 0; first_low = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge HCLK);
            if (!PERIPH_RESETn) begin
                lows++;
                if (first_low < 0) first_low = n;
            end
            if (n == busy + 1) APB_BUSY = 1'b0;
            if (CFG_ACK) begin
                lat = n; err = CFG_ERR; hold = APB_HOLD;
                break;
            end
        end
        APB_BUSY = 1'b0;
    endtask

    initial begin
        int   lat, lows, first_low, seen;
        logic err, hold;
        v[0] = '{8'd4,   8'd8,   8'd16, 1'b0, 0,    20,  1'b0, 8'd4,   8'd8,   8'd16, 0};
        v[1] = '{8'd3,   8'd5,   8'd7,  1'b0, 5,    25,  1'b0, 8'd3,   8'd5,   8'd7,  0};
        v[2] = '{8'd9,   8'd0,   8'd1,  1'b0, 0,    1,   1'b1, 8'd3,   8'd5,   8'd7,  0};
        v[3] = '{8'd6,   8'd6,   8'd6,  1'b1, 0,    24,  1'b0, 8'd6,   8'd6,   8'd6,  4};
        v[4] = '{8'd6,   8'd6,   8'd6,  1'b0, 0,    20,  1'b0, 8'd6,   8'd6,   8'd6,  0};
        v[5] = '{8'd0,   8'd1,   8'd1,  1'b1, 0,    1,   1'b1, 8'd6,   8'd6,   8'd6,  0};
        v[6] = '{8'd1,   8'd1,   8'd1,  1'b0, 1000, 256, 1'b1, 8'd6,   8'd6,   8'd6,  0};
        v[7] = '{8'd255, 8'd128, 8'd1,  1'b0, 0,    20,  1'b0, 8'd255, 8'd128, 8'd1,  0};

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_pclk_div", PCLK_PCLKG_DIV, 2);
        chk("rst_tim_div", TIMCLK_DIV, 2);
        chk("rst_wdog_div", WDOGCLK_DIV, 2);
        chk("rst_apb_active", APB_ACTIVE, 0);
        chk("rst_apb_hold", APB_HOLD, 0);
        chk("rst_periph_resetn", PERIPH_RESETn, 1);
        chk("rst_ack", CFG_ACK, 0);
        chk("rst_busy", BUSY, 0);
        HRESETn = 1'b1;
        APB_REQ = 1'b1;
        @(negedge HCLK);
        chk("apb_active_follow", APB_ACTIVE, 1);

        for (int i = 0; i < 8; i++) begin
            APB_BUSY = v[i].busy > 0;
            launch(v[i].p, v[i].t, v[i].w, v[i].rst);
            wait_ack(v[i].busy, lat, err, hold, lows, first_low);
            chk($sformatf("v%0d_latency", i), lat, v[i].lat);
            chk($sformatf("v%0d_err", i), err, v[i].err);
            chk($sformatf("v%0d_hold_at_ack", i), hold, 0);
            chk($sformatf("v%0d_reset_cycles", i), lows, v[i].lows);
            chk($sformatf("v%0d_pclk_div", i), PCLK_PCLKG_DIV, v[i].ep);
            chk($sformatf("v%0d_tim_div", i), TIMCLK_DIV, v[i].et);
            chk($sformatf("v%0d_wdog_div", i), WDOGCLK_DIV, v[i].ew);
            repeat (3) @(negedge HCLK);
        end

        launch(8'd4, 8'd8, 8'd16, 1'b0);
        for (int n = 1; n <= 22; n++) begin
            @(negedge HCLK);
            if (n == 1) begin
                chk("seq_drain_active", APB_ACTIVE, 1);
                chk("seq_drain_hold", APB_HOLD, 1);
                chk("seq_drain_busy", BUSY, 1);
            end
            if (n == 2) begin
                chk("seq_gate_hold", APB_HOLD, 1);
                chk("seq_gate_old_div", PCLK_PCLKG_DIV, 255);
            end
            if (n >= 2 && n <= 20) chk($sformatf("seq_gated_active_c%0d", n), APB_ACTIVE, 0);
            if (n == 4) chk("seq_settle_new_div", PCLK_PCLKG_DIV, 4);
            if (n == 19) chk("seq_settle_no_ack", CFG_ACK, 0);
            if (n == 20) chk("seq_done_ack", CFG_ACK, 1);
            if (n == 21) begin
                chk("seq_idle_active_lag", APB_ACTIVE, 0);
                chk("seq_idle_ack_pulse", CFG_ACK, 0);
                chk("seq_idle_busy", BUSY, 0);
            end
            if (n == 22) chk("seq_idle_active_resume", APB_ACTIVE, 1);
        end

        repeat (2) @(negedge HCLK);
        launch(8'd5, 8'd5, 8'd5, 1'b1);
        wait_ack(0, lat, err, hold, lows, first_low);
        chk("rstp_first_low_cycle", first_low, 20);
        chk("rstp_low_cycles", lows, 4);
        chk("rstp_latency", lat, 24);
        chk("rstp_resetn_at_ack", PERIPH_RESETn, 1);

        repeat (2) @(negedge HCLK);
        launch(8'd9, 8'd9, 8'd9, 1'b0);
        repeat (10) @(negedge HCLK);
        chk("mid_settle_div_loaded", PCLK_PCLKG_DIV, 9);
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        chk("mid_rst_pclk_div", PCLK_PCLKG_DIV, 2);
        chk("mid_rst_tim_div", TIMCLK_DIV, 2);
        chk("mid_rst_wdog_div", WDOGCLK_DIV, 2);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_hold", APB_HOLD, 0);
        chk("mid_rst_ack", CFG_ACK, 0);
        seen = 0;
        repeat (25) begin
            @(negedge HCLK);
            if (CFG_ACK) seen++;
        end
        chk("mid_rst_no_late_ack", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
